// File: rtl/wpa2_nios2_debug_scan_master_if.sv
// Command/response bus between an on-chip debug controller (master) and
// the virtual-JTAG scan engine (slave).
interface wpa2_nios2_debug_scan_master_if #(
   parameter int DR_WIDTH = 38
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_ir;
   logic [DR_WIDTH-1:0] cmd_data;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_data;
   logic [1:0]          rsp_ir_out;
   logic                rsp_err;

   modport master (
      output cmd_valid, cmd_ir, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_ir_out, rsp_err
   );
endinterface

// File: rtl/wpa2_nios2_debug_scan_master.sv
// Drives the Nios II debug slave's virtual-JTAG port: one UIR/CDR/SDR/UDR scan
// per command. Optional IR readback check enabled by WPA2_DBG_SCAN_IRCHK_EN.
module wpa2_nios2_debug_scan_master #(
   parameter int TCK_HALF = 2,
   parameter int DR_WIDTH = 38
) (
   input  logic       clk,
   input  logic       reset_n,
   wpa2_nios2_debug_scan_master_if.slave bus,
   output logic       vji_tck,
   output logic       vji_tdi,
   input  logic       vji_tdo,
   output logic [1:0] vji_ir_in,
   input  logic [1:0] vji_ir_out,
   output logic       vji_uir,
   output logic       vji_cdr,
   output logic       vji_sdr,
   output logic       vji_udr,
   output logic       vji_rti
);
   localparam int PER = 2 * TCK_HALF;
   localparam int CW  = $clog2(PER + 1);
   localparam int BW  = $clog2(DR_WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PER - 1);
   localparam logic [CW-1:0] CNT_RISE = CW'(TCK_HALF - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP
   } state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [BW-1:0]       bit_q;
   logic [DR_WIDTH-1:0] shift_q;
   logic [DR_WIDTH-1:0] rsp_data_q;
   logic [1:0]          rsp_ir_out_q;
   logic [1:0]          ir_in_q;
   logic                cmd_ready_q, rsp_valid_q;
   logic                tck_q, tdi_q;
   logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
   logic                per_end, tck_rise;

   // tck_rise marks the clk edge that drives tck high; per_end the last cycle of a period
   assign per_end  = (cnt_q == CNT_LAST);
   assign tck_rise = (cnt_q == CNT_RISE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         rsp_data_q   <= '0;
         rsp_ir_out_q <= '0;
         ir_in_q      <= '0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         tck_q        <= 1'b0;
         tdi_q        <= 1'b0;
         uir_q        <= 1'b0;
         cdr_q        <= 1'b0;
         sdr_q        <= 1'b0;
         udr_q        <= 1'b0;
         rti_q        <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  ir_in_q     <= bus.cmd_ir;
                  shift_q     <= bus.cmd_data;
                  cnt_q       <= '0;
                  tck_q       <= 1'b0;
                  cmd_ready_q <= 1'b0;
                  rti_q       <= 1'b0;
                  uir_q       <= 1'b1;
                  state_q     <= S_UIR;
               end
            end
            S_RSP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  rti_q       <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               // Every scan phase is a whole number of tck periods: low half, then high half
               cnt_q <= per_end ? '0 : cnt_q + 1'b1;
               tck_q <= !per_end && (cnt_q >= CNT_RISE);
               case (state_q)
                  S_UIR: begin
                     if (tck_rise) rsp_ir_out_q <= vji_ir_out;
                     if (per_end) begin
                        uir_q   <= 1'b0;
                        cdr_q   <= 1'b1;
                        state_q <= S_CDR;
                     end
                  end
                  S_CDR: begin
                     if (per_end) begin
                        cdr_q   <= 1'b0;
                        sdr_q   <= 1'b1;
                        tdi_q   <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= S_SDR;
                     end
                  end
                  S_SDR: begin
                     if (tck_rise) shift_q <= {vji_tdo, shift_q[DR_WIDTH-1:1]};
                     if (per_end) begin
                        if (bit_q == BIT_LAST) begin
                           sdr_q   <= 1'b0;
                           udr_q   <= 1'b1;
                           tdi_q   <= 1'b0;
                           state_q <= S_UDR;
                        end else begin
                           // shift already happened on this period's rising edge
                           bit_q <= bit_q + 1'b1;
                           tdi_q <= shift_q[0];
                        end
                     end
                  end
                  S_UDR: begin
                     if (per_end) begin
                        udr_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= shift_q;
                        state_q     <= S_RSP;
                     end
                  end
                  default: state_q <= S_IDLE;
               endcase
            end
         endcase
      end
   end

`ifdef WPA2_DBG_SCAN_IRCHK_EN
   logic rsp_err_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_err_q <= 1'b0;
      end else if (state_q == S_IDLE && bus.cmd_valid) begin
         rsp_err_q <= 1'b0;
      end else if (state_q == S_UIR && tck_rise) begin
         rsp_err_q <= (vji_ir_out != ir_in_q);
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_ir_out = rsp_ir_out_q;
   assign vji_tck        = tck_q;
   assign vji_tdi        = tdi_q;
   assign vji_ir_in      = ir_in_q;
   assign vji_uir        = uir_q;
   assign vji_cdr        = cdr_q;
   assign vji_sdr        = sdr_q;
   assign vji_udr        = udr_q;
   assign vji_rti        = rti_q;
endmodule

// File: tb/tb_wpa2_nios2_debug_scan_master.sv
// Directed bench for the virtual-JTAG scan master: timing, loopback data,
// backpressure, mid-scan reset and IR check.
module tb_wpa2_nios2_debug_scan_master;
   localparam int DRW = 38;
   localparam int LAT = (DRW + 3) * 2 * 2;
`ifdef WPA2_DBG_SCAN_IRCHK_EN
   localparam bit IRCHK = 1'b1;
`else
   localparam bit IRCHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       vji_tck, vji_tdi, vji_tdo;
   logic [1:0] vji_ir_in, vji_ir_out;
   logic       vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
   logic       tdo_const_mode, tdo_const_val, tdi_dly;

   int checks = 0;
   int errors = 0;

   int rise_uir = 0, rise_cdr = 0, rise_sdr = 0, rise_udr = 0;
   int tdi_hi_change = 0, tdi_one_sdr = 0;
   logic tck_prev = 1'b0, tdi_prev = 1'b0;

   wpa2_nios2_debug_scan_master_if #(.DR_WIDTH(DRW)) bus ();

   wpa2_nios2_debug_scan_master #(.TCK_HALF(2), .DR_WIDTH(DRW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .vji_tck    (vji_tck),
      .vji_tdi    (vji_tdi),
      .vji_tdo    (vji_tdo),
      .vji_ir_in  (vji_ir_in),
      .vji_ir_out (vji_ir_out),
      .vji_uir    (vji_uir),
      .vji_cdr    (vji_cdr),
      .vji_sdr    (vji_sdr),
      .vji_udr    (vji_udr),
      .vji_rti    (vji_rti)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tdi_dly <= vji_tdi;
   assign vji_tdo = tdo_const_mode ? tdo_const_val : tdi_dly;

   // Protocol monitor: counts tck rising edges per phase and tdi misbehaviour
   always @(negedge clk) begin
      if (vji_tck && !tck_prev) begin
         if (vji_uir) rise_uir++;
         if (vji_cdr) rise_cdr++;
         if (vji_sdr) rise_sdr++;
         if (vji_udr) rise_udr++;
      end
      if (vji_tck && tck_prev && (vji_tdi != tdi_prev)) tdi_hi_change++;
      if (vji_sdr && vji_tdi) tdi_one_sdr++;
      tck_prev = vji_tck;
      tdi_prev = vji_tdi;
   end

   task automatic send_cmd(input logic [1:0] ir, input logic [DRW-1:0] data);
      int n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept cmd_ready=%b required=1", bus.cmd_ready);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_ir    = ir;
      bus.cmd_data  = data;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_ir    = 2'b00;
      bus.cmd_data  = '0;
   endtask

   // Counts clk edges after the accept edge until rsp_valid is seen
   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.rsp_valid) return;
      end
      lat = -1;
   endtask

   task automatic consume();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (vji_rti !== 1'b1) begin errors++; $display("FAIL reset_rti got=%b required=1", vji_rti); end
      checks++;
      if (vji_tck !== 1'b0) begin errors++; $display("FAIL reset_tck got=%b required=0", vji_tck); end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b required=1", bus.cmd_ready); end
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b required=0", bus.rsp_valid); end
      checks++;
      if (bus.rsp_data !== '0 || vji_ir_in !== 2'b00 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs rsp_data=%h ir_in=%b err=%b required=0/0/0", bus.rsp_data, vji_ir_in, bus.rsp_err);
      end
      $display("txn reset done");
   endtask

   task automatic test_loopback();
      int lat;
      int b_uir, b_cdr, b_sdr, b_udr, b_hi;
      logic [DRW-1:0] d = 38'h2A_5A5A_A5A5;
      tdo_const_mode = 1'b0;
      vji_ir_out = 2'b01;
      b_uir = rise_uir; b_cdr = rise_cdr; b_sdr = rise_sdr; b_udr = rise_udr; b_hi = tdi_hi_change;
      send_cmd(2'b01, d);
      wait_rsp(lat);
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL loop_latency got=%0d required=%0d", lat, LAT); end
      checks++;
      if (bus.rsp_data !== d) begin errors++; $display("FAIL loop_data got=%h required=%h", bus.rsp_data, d); end
      checks++;
      if (rise_sdr - b_sdr != DRW) begin errors++; $display("FAIL loop_sdr_edges got=%0d required=%0d", rise_sdr - b_sdr, DRW); end
      checks++;
      if (rise_uir - b_uir != 1 || rise_cdr - b_cdr != 1 || rise_udr - b_udr != 1) begin
         errors++;
         $display("FAIL loop_phase_edges uir=%0d cdr=%0d udr=%0d required=1/1/1",
                  rise_uir - b_uir, rise_cdr - b_cdr, rise_udr - b_udr);
      end
      checks++;
      if (tdi_hi_change != b_hi) begin errors++; $display("FAIL loop_tdi_while_tck_high got=%0d required=0", tdi_hi_change - b_hi); end
      checks++;
      if (bus.rsp_ir_out !== 2'b01 || vji_ir_in !== 2'b01 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL loop_ir ir_out=%b ir_in=%b err=%b required=01/01/0", bus.rsp_ir_out, vji_ir_in, bus.rsp_err);
      end
      checks++;
      if (vji_rti !== 1'b0 || vji_tck !== 1'b0 || vji_udr !== 1'b0) begin
         errors++;
         $display("FAIL rsp_strobes rti=%b tck=%b udr=%b required=0/0/0", vji_rti, vji_tck, vji_udr);
      end
      $display("txn loopback lat=%0d data=%h", lat, bus.rsp_data);
      consume();
   endtask

   task automatic test_const_one();
      int lat, b_one;
      tdo_const_mode = 1'b1;
      tdo_const_val  = 1'b1;
      b_one = tdi_one_sdr;
      send_cmd(2'b01, '0);
      wait_rsp(lat);
      checks++;
      if (bus.rsp_data !== 38'h3F_FFFF_FFFF) begin errors++; $display("FAIL ones_data got=%h required=3fffffffff", bus.rsp_data); end
      checks++;
      if (tdi_one_sdr != b_one) begin errors++; $display("FAIL ones_tdi_in_sdr high_cycles=%0d required=0", tdi_one_sdr - b_one); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL ones_latency got=%0d required=%0d", lat, LAT); end
      $display("txn const_one lat=%0d data=%h", lat, bus.rsp_data);
      consume();
      tdo_const_mode = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [DRW-1:0] d1 = 38'h01_2345_6789;
      logic [DRW-1:0] d2 = 38'h3E_DCBA_9876;
      send_cmd(2'b01, d1);
      wait_rsp(lat);
      bus.cmd_valid = 1'b1;
      bus.cmd_ir    = 2'b01;
      bus.cmd_data  = d2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_rsp cyc=%0d valid=%b data=%h ready=%b required=1/%h/0",
                     i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, d1);
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || vji_rti !== 1'b1) begin
         errors++;
         $display("FAIL consume valid=%b ready=%b rti=%b required=0/1/1", bus.rsp_valid, bus.cmd_ready, vji_rti);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      @(negedge clk);
      checks++;
      if (vji_uir !== 1'b1 || bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL second_accept uir=%b ready=%b required=1/0", vji_uir, bus.cmd_ready);
      end
      wait_rsp(lat);
      checks++;
      if (bus.rsp_data !== d2 || lat != LAT) begin
         errors++;
         $display("FAIL second_rsp data=%h lat=%0d required=%h/%0d", bus.rsp_data, lat, d2, LAT);
      end
      $display("txn back_to_back lat=%0d data=%h", lat, bus.rsp_data);
      consume();
   endtask

   task automatic test_reset_mid_scan();
      int lat, base, n;
      logic [DRW-1:0] d = 38'h15_0F0F_F0F0;
      base = rise_sdr;
      send_cmd(2'b10, 38'h2B_CDEF_0123);
      n = 0;
      while ((rise_sdr - base) < 15 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rise_sdr - base < 15) begin errors++; $display("FAIL mid_reach_sdr edges=%0d required=15", rise_sdr - base); end
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
          bus.rsp_ir_out !== 2'b00 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_bus ready=%b valid=%b data=%h ir_out=%b err=%b required=1/0/0/00/0",
                  bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_ir_out, bus.rsp_err);
      end
      checks++;
      if (vji_tck !== 1'b0 || vji_tdi !== 1'b0 || vji_ir_in !== 2'b00 || vji_uir !== 1'b0 ||
          vji_cdr !== 1'b0 || vji_sdr !== 1'b0 || vji_udr !== 1'b0 || vji_rti !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_vji tck=%b tdi=%b ir_in=%b uir=%b cdr=%b sdr=%b udr=%b rti=%b required=0/0/00/0/0/0/0/1",
                  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti);
      end
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) n++;
      end
      checks++;
      if (n != 0) begin errors++; $display("FAIL mid_no_partial rsp_valid_cycles=%0d required=0", n); end
      vji_ir_out = 2'b01;
      send_cmd(2'b01, d);
      wait_rsp(lat);
      checks++;
      if (bus.rsp_data !== d || lat != LAT) begin
         errors++;
         $display("FAIL after_reset_rsp data=%h lat=%0d required=%h/%0d", bus.rsp_data, lat, d, LAT);
      end
      $display("txn reset_mid_scan then data=%h", bus.rsp_data);
      consume();
   endtask

   task automatic test_irchk();
      int lat;
      vji_ir_out = 2'b10;
      send_cmd(2'b01, 38'h00_0000_00FF);
      wait_rsp(lat);
      checks++;
      if (bus.rsp_ir_out !== 2'b10) begin errors++; $display("FAIL irchk_ir_out got=%b required=10", bus.rsp_ir_out); end
      checks++;
      if (bus.rsp_err !== IRCHK) begin errors++; $display("FAIL irchk_mismatch_err got=%b required=%b", bus.rsp_err, IRCHK); end
      $display("txn irchk mismatch err=%b ir_out=%b", bus.rsp_err, bus.rsp_ir_out);
      consume();
      vji_ir_out = 2'b01;
      send_cmd(2'b01, 38'h00_0000_00FF);
      wait_rsp(lat);
      checks++;
      if (bus.rsp_err !== 1'b0 || bus.rsp_ir_out !== 2'b01) begin
         errors++;
         $display("FAIL irchk_match err=%b ir_out=%b required=0/01", bus.rsp_err, bus.rsp_ir_out);
      end
      $display("txn irchk match err=%b ir_out=%b", bus.rsp_err, bus.rsp_ir_out);
      consume();
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_ir     = 2'b00;
      bus.cmd_data   = '0;
      bus.rsp_ready  = 1'b0;
      vji_ir_out     = 2'b00;
      tdo_const_mode = 1'b0;
      tdo_const_val  = 1'b0;
      test_reset();
      test_loopback();
      test_const_one();
      test_back_to_back();
      test_reset_mid_scan();
      test_irchk();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
